// File: rtl/ram_slot_arbiter.sv
// rtl/ram_slot_arbiter.sv - shares extension-owned 512k SRAM slots between video, port A and port B
//
// Purpose: arbitrates each free SRAM slot (announced by PRE one cycle ahead) between
// the video fetcher (V, read only, first slot of a pair only) and two auxiliary
// ports A/B, drives the SRAM pins during the slot and acknowledges the winner.
//
// Build option: ARB_ROUNDROBIN_EN
//   defined   - A/B alternate when both request (pointer resets to A)
//   undefined - fixed priority, A over B
//
// Ports:
//   CLKx4, RST               clock (posedge), asynchronous active-high reset
//   PRE, SLOT, SLOT_ID       slot timing from the bus-phase generator
//   VREQ, VADDR, VACK        video read request / address / completion pulse
//   AREQ, AWR, AADDR, AWD, AACK   port A request, write flag, address, data, ack
//   BREQ, BWR, BADDR, BWD, BACK   port B request, write flag, address, data, ack
//   RDATA                    last read data, held until the next read completes
//   RA, RDO, RDOE, nWE, RDIN SRAM address, write data, data drive enable, write strobe, read data
//   IDLE                     pulse in a slot cycle that nobody was granted
module ram_slot_arbiter #(
  parameter int AW = 19,
  parameter int DW = 8
) (
  input  logic          CLKx4,
  input  logic          RST,
  input  logic          PRE,
  input  logic          SLOT,
  input  logic          SLOT_ID,
  input  logic          VREQ,
  input  logic [AW-1:0] VADDR,
  output logic          VACK,
  input  logic          AREQ,
  input  logic          AWR,
  input  logic [AW-1:0] AADDR,
  input  logic [DW-1:0] AWD,
  output logic          AACK,
  input  logic          BREQ,
  input  logic          BWR,
  input  logic [AW-1:0] BADDR,
  input  logic [DW-1:0] BWD,
  output logic          BACK,
  output logic [DW-1:0] RDATA,
  output logic [AW-1:0] RA,
  output logic [DW-1:0] RDO,
  output logic          RDOE,
  output logic          nWE,
  input  logic [DW-1:0] RDIN,
  output logic          IDLE
);

  typedef enum logic [1:0] {S_WAIT, S_ARMED, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_V, OWN_A, OWN_B} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [DW-1:0] rdo_q, rdo_d;
  logic          rdoe_q, rdoe_d;
  logic          nwe_q, nwe_d;
  logic          idle_q, idle_d;
  logic          vack_q, vack_d;
  logic          aack_q, aack_d;
  logic          back_q, back_d;
  logic [DW-1:0] rdata_q, rdata_d;
`ifdef ARB_ROUNDROBIN_EN
  // 0: A has priority on a tie, 1: B has priority on a tie
  logic          rr_q, rr_d;
`endif

  // Candidate grant, evaluated every cycle and used only at an accepted PRE
  owner_t        gnt_owner;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wd;
  logic          gnt_wr;
  logic          a_wins;
  logic          pre_ok;

  // PRE coinciding with SLOT is a protocol error and is ignored
  assign pre_ok = PRE && !SLOT;

  always_comb begin
`ifdef ARB_ROUNDROBIN_EN
    a_wins = AREQ && (!BREQ || !rr_q);
`else
    a_wins = AREQ;
`endif
    gnt_owner = OWN_NONE;
    gnt_addr  = '0;
    gnt_wd    = '0;
    gnt_wr    = 1'b0;
    if (!SLOT_ID && VREQ) begin
      gnt_owner = OWN_V;
      gnt_addr  = VADDR;
    end else if (a_wins) begin
      gnt_owner = OWN_A;
      gnt_addr  = AADDR;
      gnt_wd    = AWD;
      gnt_wr    = AWR;
    end else if (BREQ) begin
      gnt_owner = OWN_B;
      gnt_addr  = BADDR;
      gnt_wd    = BWD;
      gnt_wr    = BWR;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    ra_d    = ra_q;
    rdo_d   = rdo_q;
    rdata_d = rdata_q;
    // Strobes, idle and acks are single-cycle: released on every edge unless re-armed
    rdoe_d  = 1'b0;
    nwe_d   = 1'b1;
    idle_d  = 1'b0;
    vack_d  = 1'b0;
    aack_d  = 1'b0;
    back_d  = 1'b0;
`ifdef ARB_ROUNDROBIN_EN
    rr_d    = rr_q;
`endif

    unique case (state_q)
      S_ARMED: begin
        owner_d = OWN_NONE;
        if (SLOT) begin
          state_d = S_DONE;
          vack_d  = (owner_q == OWN_V);
          aack_d  = (owner_q == OWN_A);
          back_d  = (owner_q == OWN_B);
          if (owner_q != OWN_NONE && !wr_q) begin
            rdata_d = RDIN;
          end
`ifdef ARB_ROUNDROBIN_EN
          // Pointer commits only on completion, so an aborted grant leaves it untouched
          if (owner_q == OWN_A) rr_d = 1'b1;
          if (owner_q == OWN_B) rr_d = 1'b0;
`endif
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        // S_WAIT and S_DONE both accept a new PRE
        state_d = S_WAIT;
        if (pre_ok) begin
          state_d = S_ARMED;
          owner_d = gnt_owner;
          wr_d    = gnt_wr;
          if (gnt_owner == OWN_NONE) begin
            idle_d = 1'b1;
          end else begin
            ra_d   = gnt_addr;
            rdoe_d = gnt_wr;
            nwe_d  = !gnt_wr;
            if (gnt_wr) rdo_d = gnt_wd;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLKx4 or posedge RST) begin
    if (RST) begin
      state_q <= S_WAIT;
      owner_q <= OWN_NONE;
      wr_q    <= 1'b0;
      ra_q    <= '0;
      rdo_q   <= '0;
      rdoe_q  <= 1'b0;
      nwe_q   <= 1'b1;
      idle_q  <= 1'b0;
      vack_q  <= 1'b0;
      aack_q  <= 1'b0;
      back_q  <= 1'b0;
      rdata_q <= '0;
`ifdef ARB_ROUNDROBIN_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      ra_q    <= ra_d;
      rdo_q   <= rdo_d;
      rdoe_q  <= rdoe_d;
      nwe_q   <= nwe_d;
      idle_q  <= idle_d;
      vack_q  <= vack_d;
      aack_q  <= aack_d;
      back_q  <= back_d;
      rdata_q <= rdata_d;
`ifdef ARB_ROUNDROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign RA    = ra_q;
  assign RDO   = rdo_q;
  assign RDOE  = rdoe_q;
  assign nWE   = nwe_q;
  assign IDLE  = idle_q;
  assign VACK  = vack_q;
  assign AACK  = aack_q;
  assign BACK  = back_q;
  assign RDATA = rdata_q;

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// tb/tb_ram_slot_arbiter.sv - directed self-checking bench for ram_slot_arbiter
module tb_ram_slot_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;

  logic          CLKx4 = 1'b0;
  logic          RST = 1'b1;
  logic          PRE = 1'b0, SLOT = 1'b0, SLOT_ID = 1'b0;
  logic          VREQ = 1'b0;
  logic [AW-1:0] VADDR = '0;
  logic          VACK;
  logic          AREQ = 1'b0, AWR = 1'b0;
  logic [AW-1:0] AADDR = '0;
  logic [DW-1:0] AWD = '0;
  logic          AACK;
  logic          BREQ = 1'b0, BWR = 1'b0;
  logic [AW-1:0] BADDR = '0;
  logic [DW-1:0] BWD = '0;
  logic          BACK;
  logic [DW-1:0] RDATA;
  logic [AW-1:0] RA;
  logic [DW-1:0] RDO;
  logic          RDOE, nWE, IDLE;
  logic [DW-1:0] RDIN = '0;

  int checks = 0;
  int passes = 0;
  logic exp_a;

  ram_slot_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLKx4(CLKx4), .RST(RST), .PRE(PRE), .SLOT(SLOT), .SLOT_ID(SLOT_ID),
    .VREQ(VREQ), .VADDR(VADDR), .VACK(VACK),
    .AREQ(AREQ), .AWR(AWR), .AADDR(AADDR), .AWD(AWD), .AACK(AACK),
    .BREQ(BREQ), .BWR(BWR), .BADDR(BADDR), .BWD(BWD), .BACK(BACK),
    .RDATA(RDATA), .RA(RA), .RDO(RDO), .RDOE(RDOE), .nWE(nWE),
    .RDIN(RDIN), .IDLE(IDLE)
  );

  always #20 CLKx4 = ~CLKx4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive slot-timing inputs for one cycle, then land 1 time unit after the next edge
  task automatic cyc(input logic p, input logic s, input logic id);
    PRE = p; SLOT = s; SLOT_ID = id;
    @(posedge CLKx4); #1;
  endtask

  task automatic acks(input string tag, input logic v, input logic a, input logic b);
    check({tag, "_vack"}, VACK, v);
    check({tag, "_aack"}, AACK, a);
    check({tag, "_back"}, BACK, b);
  endtask

  initial begin
    // Reset values
    @(posedge CLKx4); #1;
    check("rst_ra", RA, 0);
    check("rst_rdo", RDO, 0);
    check("rst_rdoe", RDOE, 0);
    check("rst_nwe", nWE, 1);
    check("rst_idle", IDLE, 0);
    check("rst_rdata", RDATA, 0);
    acks("rst", 0, 0, 0);
    RST = 1'b0;
    cyc(0, 0, 0);

    // Video read on slot 0
    VREQ = 1; VADDR = 19'h12345; RDIN = 8'h3C;
    cyc(1, 0, 0);
    check("v_ra", RA, 19'h12345);
    check("v_nwe", nWE, 1);
    check("v_rdoe", RDOE, 0);
    check("v_idle", IDLE, 0);
    acks("v_armed", 0, 0, 0);
    cyc(0, 1, 0);
    acks("v_done", 1, 0, 0);
    check("v_rdata", RDATA, 8'h3C);
    cyc(0, 0, 0);
    check("v_after", VACK, 0);

    // Video on slot 1 is never granted -> idle slot, RA held
    cyc(1, 0, 1);
    check("v1_idle", IDLE, 1);
    check("v1_ra_hold", RA, 19'h12345);
    check("v1_nwe", nWE, 1);
    cyc(0, 1, 0);
    acks("v1_done", 0, 0, 0);
    check("v1_idle_off", IDLE, 0);
    cyc(0, 0, 0);

    // Slot pair: slot 0 to V, slot 1 to A write
    VADDR = 19'h00100; RDIN = 8'h11;
    AREQ = 1; AWR = 1; AADDR = 19'h7FF00; AWD = 8'hA5;
    cyc(1, 0, 0);
    check("pair_v_ra", RA, 19'h00100);
    check("pair_v_nwe", nWE, 1);
    cyc(0, 1, 0);
    acks("pair_v_done", 1, 0, 0);
    check("pair_v_rdata", RDATA, 8'h11);
    cyc(1, 0, 1);
    VREQ = 0;
    check("pair_a_ra", RA, 19'h7FF00);
    check("pair_a_nwe", nWE, 0);
    check("pair_a_rdoe", RDOE, 1);
    check("pair_a_rdo", RDO, 8'hA5);
    acks("pair_a_armed", 0, 0, 0);
    cyc(0, 1, 0);
    check("pair_a_nwe_rel", nWE, 1);
    check("pair_a_rdoe_rel", RDOE, 0);
    acks("pair_a_done", 0, 1, 0);
    check("pair_a_rdata_keep", RDATA, 8'h11);
    AREQ = 0;
    cyc(0, 0, 0);
    check("pair_a_after", AACK, 0);

    // Fresh pointer, then A and B both requesting reads for four slots
    RST = 1; @(posedge CLKx4); #1; RST = 0;
    AREQ = 1; AWR = 0; AADDR = 19'h00AAA;
    BREQ = 1; BWR = 0; BADDR = 19'h00BBB;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUNDROBIN_EN
      exp_a = (k % 2 == 0);
`else
      exp_a = 1'b1;
`endif
      RDIN = 8'h40 + 8'(k);
      cyc(1, 0, 0);
      check("rr_ra", RA, exp_a ? 19'h00AAA : 19'h00BBB);
      cyc(0, 1, 0);
      acks("rr_done", 0, exp_a, !exp_a);
      check("rr_rdata", RDATA, 8'h40 + k);
      cyc(0, 0, 0);
    end

    // Abort: PRE without SLOT; pointer is back at A in both builds
    AWR = 1; AADDR = 19'h7FF00; AWD = 8'h5C;
    cyc(1, 0, 0);
    check("ab_nwe_armed", nWE, 0);
    check("ab_ra", RA, 19'h7FF00);
    cyc(0, 0, 0);
    check("ab_nwe_rel", nWE, 1);
    check("ab_rdoe_rel", RDOE, 0);
    acks("ab_noack", 0, 0, 0);
    cyc(0, 0, 0);
    acks("ab_noack2", 0, 0, 0);
    cyc(1, 0, 0);
    check("ab_regrant_ra", RA, 19'h7FF00);
    cyc(0, 1, 0);
    acks("ab_regrant", 0, 1, 0);
    cyc(0, 0, 0);

    // Reset in the middle of an armed write
    BWR = 1;
    cyc(1, 0, 0);
    check("mr_nwe_armed", nWE, 0);
    RST = 1; #1;
    check("mr_nwe", nWE, 1);
    check("mr_rdoe", RDOE, 0);
    check("mr_ra", RA, 0);
    acks("mr_now", 0, 0, 0);
    SLOT = 1; PRE = 0;
    @(posedge CLKx4); #1;
    acks("mr_noack", 0, 0, 0);
    RST = 0;
    AWR = 0; BWR = 0; RDIN = 8'h5A;
    cyc(1, 0, 0);
    check("mr_first_ra", RA, 19'h7FF00);
    cyc(0, 1, 0);
    acks("mr_first", 0, 1, 0);
    check("mr_rdata", RDATA, 8'h5A);
    cyc(0, 0, 0);

    // Back-to-back: idle slot then B read
    AREQ = 0; BREQ = 0; RDIN = 8'hEE;
    cyc(1, 0, 0);
    check("bb_idle", IDLE, 1);
    check("bb_ra_hold", RA, 19'h7FF00);
    cyc(0, 1, 0);
    acks("bb_idle_done", 0, 0, 0);
    check("bb_rdata_hold", RDATA, 8'h5A);
    BREQ = 1; BWR = 0; BADDR = 19'h40001;
    cyc(1, 0, 1);
    check("bb_b_ra", RA, 19'h40001);
    check("bb_b_idle", IDLE, 0);
    check("bb_rdata_hold2", RDATA, 8'h5A);
    RDIN = 8'h81;
    cyc(0, 1, 0);
    acks("bb_b_done", 0, 0, 1);
    check("bb_b_rdata", RDATA, 8'h81);
    BREQ = 0;
    cyc(0, 0, 0);
    check("bb_b_after", BACK, 0);
    check("bb_rdata_held", RDATA, 8'h81);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
